// File: rtl/refill_return_buffer_pkg.sv
// Shared parameters and state encoding for the line-refill return buffer.
// The defaults here match the cache geometry the buffer is normally built for.
package refill_return_buffer_pkg;

    localparam int WORD_W_DEF     = 32;
    localparam int LINE_WORDS_DEF = 4;
    localparam int OFF_W_DEF      = $clog2(LINE_WORDS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } fill_state_e;

endpackage

// File: rtl/refill_word_array.sv
// Line storage: one register per word with a valid bit, a bulk valid-clear,
// and a combinational read port that forwards a same-cycle write.
module refill_word_array
    import refill_return_buffer_pkg::*;
#(
    parameter  int WORD_W     = WORD_W_DEF,
    parameter  int LINE_WORDS = LINE_WORDS_DEF,
    localparam int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clr,
    input  logic                         we,
    input  logic [OFF_W-1:0]             waddr,
    input  logic [WORD_W-1:0]            wdata,
    input  logic [OFF_W-1:0]             raddr,
    output logic [WORD_W-1:0]            rd_word,
    output logic                         rd_hit,
    output logic [LINE_WORDS*WORD_W-1:0] line_out
);

    logic [LINE_WORDS-1:0][WORD_W-1:0] data_q;
    logic [LINE_WORDS-1:0]             vld_q;

    // NOTE: the data words are reset too, because line_out and rd_word must read
    // zero straight out of reset rather than whatever the flops powered up with.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            vld_q  <= '0;
        end else begin
            if (clr) begin
                vld_q <= '0;
            end
            if (we) begin
                data_q[waddr] <= wdata;
                vld_q[waddr]  <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        rd_word = data_q[raddr];
        rd_hit  = vld_q[raddr];
        if (we && (waddr == raddr)) begin
            rd_word = wdata;
            rd_hit  = 1'b1;
        end
    end

    assign line_out = data_q;

endmodule

// File: rtl/refill_return_buffer.sv
// Assembles one cache line from burst beats (linear or critical-word-first),
// exposes words as they land, and holds the full line until it is consumed.
module refill_return_buffer
    import refill_return_buffer_pkg::*;
#(
    parameter  int WORD_W     = WORD_W_DEF,
    parameter  int LINE_WORDS = LINE_WORDS_DEF,
    parameter  bit WRAP_MODE  = 1'b1,
    localparam int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         fill_start,
    input  logic [OFF_W-1:0]             fill_offset,
    input  logic                         beat_valid,
    output logic                         beat_ready,
    input  logic [WORD_W-1:0]            beat_data,
    input  logic                         beat_last,
    input  logic [OFF_W-1:0]             rd_addr,
    output logic [WORD_W-1:0]            rd_word,
    output logic                         rd_hit,
    output logic                         crit_valid,
    output logic [WORD_W-1:0]            crit_word,
    output logic [LINE_WORDS*WORD_W-1:0] line_out,
    output logic                         line_valid,
    input  logic                         consume,
    output logic                         busy,
    output logic                         len_err
);

    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

    fill_state_e       state_q, state_d;
    logic [OFF_W-1:0]  wptr_q, wptr_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [OFF_W-1:0]  crit_off_q, crit_off_d;
    logic              len_err_q, len_err_d;
    logic              crit_valid_q, crit_valid_d;
    logic [WORD_W-1:0] crit_word_q, crit_word_d;

    logic accept;
    logic start;

    assign beat_ready = (state_q == ST_FILL);
    assign accept     = beat_valid && beat_ready;
    // A new fill can begin from IDLE, or straight out of FULL when the held line is consumed.
    assign start      = fill_start &&
                        ((state_q == ST_IDLE) || ((state_q == ST_FULL) && consume));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            wptr_q       <= '0;
            cnt_q        <= '0;
            crit_off_q   <= '0;
            len_err_q    <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_word_q  <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            cnt_q        <= cnt_d;
            crit_off_q   <= crit_off_d;
            len_err_q    <= len_err_d;
            crit_valid_q <= crit_valid_d;
            crit_word_q  <= crit_word_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        cnt_d        = cnt_q;
        crit_off_d   = crit_off_q;
        len_err_d    = len_err_q;
        crit_valid_d = 1'b0;
        crit_word_d  = crit_word_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    wptr_d = wptr_q + OFF_W'(1);
                    cnt_d  = cnt_q + OFF_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_FULL;
                        if (!beat_last) begin
                            len_err_d = 1'b1;
                        end
                    end else if (beat_last) begin
                        state_d   = ST_IDLE;
                        len_err_d = 1'b1;
                    end
                    if (wptr_q == crit_off_q) begin
                        crit_valid_d = 1'b1;
                        crit_word_d  = beat_data;
                    end
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d = start ? ST_FILL : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            wptr_d     = WRAP_MODE ? fill_offset : '0;
            cnt_d      = '0;
            crit_off_d = fill_offset;
            len_err_d  = 1'b0;
        end
    end

    refill_word_array #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_words (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (start),
        .we       (accept),
        .waddr    (wptr_q),
        .wdata    (beat_data),
        .raddr    (rd_addr),
        .rd_word  (rd_word),
        .rd_hit   (rd_hit),
        .line_out (line_out)
    );

    assign line_valid = (state_q == ST_FULL);
    assign busy       = (state_q != ST_IDLE);
    assign len_err    = len_err_q;
    assign crit_valid = crit_valid_q;
    assign crit_word  = crit_word_q;

endmodule
